mem_arbiter_2p: RTL
===================

Name: mem_arbiter_2p

Overview:
- Shares the single-port block RAM (1-cycle registered read, write on clock edge) between two requesters.
- Port 0 is normally the CPU-side memory path; port 1 is a loader/debug/DMA master.
- Per-cycle grant uses round-robin or fixed priority, with an optional bounded lock for atomic multi-cycle sequences.
- Returns each read's data to the requester that issued it.

Parameters:
- SIZE, 14, address width in bits, matching the RAM address port.
- DW, 32, data width.
- FIXED_PRIO, 0, 0 = round-robin, 1 = port 0 always wins when no lock is held.
- MAX_LOCK, 16, maximum consecutive cycles one port may hold a lock; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  access request, evaluated each cycle.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_lock, m1_lock  in  1  request to keep ownership on following cycles.
- m0_addr, m1_addr  in  SIZE  word address.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_gnt, m1_gnt  out  1  access accepted this cycle; combinational.
- m0_rvalid, m1_rvalid  out  1  read data valid; registered, asserted the cycle after a granted read.
- m0_rdata, m1_rdata  out  DW  read data; both driven from ram_rdata, qualified by rvalid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  SIZE  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, rr_last = 1 (port 0 wins the first contention), lock_cnt = 0, rd_tag = none.
  - m0_rvalid = m1_rvalid = 0.
  - Combinational outputs resolve to gnt = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0 while rst is low.
  - A read granted in the cycle reset asserts is discarded; no rvalid follows it.
- At most one gnt per cycle; gnt only when the matching req = 1.
- Granted port's addr/we/wdata are muxed to the RAM.
- No grant: ram_we = 0, ram_addr = 0, ram_wdata = 0.
- State IDLE:
  - Only one req high: grant it.
  - Both high, FIXED_PRIO = 1: grant port 0.
  - Both high, FIXED_PRIO = 0: grant the port other than rr_last.
  - rr_last updates to the granted port on every grant.
  - Granted port with lock = 1 moves state to LOCKi and sets lock_cnt = 1.
- State LOCKi:
  - Port i is granted whenever mi_req = 1; the other port gets gnt = 0.
  - Cycles with mi_req = 0 inside a lock grant nothing and still count toward MAX_LOCK.
  - Stay while mi_lock = 1 and lock_cnt < MAX_LOCK; increment lock_cnt each cycle.
  - mi_lock = 0 returns to IDLE at the next edge. The access in that cycle is still granted to port i.
  - lock_cnt = MAX_LOCK forces IDLE with rr_last = i and sets force_yield. While force_yield is set, the next contended IDLE cycle grants the other port regardless of FIXED_PRIO; force_yield then clears.
  - A lock request from the forced-out port is ignored until it is granted again from IDLE.
- Read return:
  - A granted read at edge t sets rd_tag = i; mi_rvalid = 1 during cycle t+1 only.
  - rdata = ram_rdata in that same cycle.
  - Back-to-back reads from alternating ports produce alternating rvalid pulses with no bubble.
- Writes: a granted write commits at the same edge. No response pulse is generated.
- Same-address write then read on consecutive cycles returns the new value.
- Read and write in the same cycle are impossible (single grant).
- Address is passed unchanged; SIZE bits, no wrap logic.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding: IDLE = 0, LOCK0 = 1, LOCK1 = 2.
  - Port index constants P0 = 0, P1 = 1.
  - MAX_LOCK counter width = 8.
- One natural sub-module, rr_pick2:
  - Combinational winner selection from req[1:0], rr_last, FIXED_PRIO, force_yield.
  - Keeps the top level to state, counter, rd_tag and muxing.

Test Plan:
- Reset then idle: rst low for 20 cycles, no req → all gnt, rvalid and ram_we stay 0; ram_addr = 0.
- Write/read port 1: write 32'h3e8 to address 70, then read address 70 next cycle → m1_rvalid one cycle after the read grant, m1_rdata = 32'h3e8, m0_rvalid stays 0.
- Round-robin contention: both ports read every cycle for 6 cycles, FIXED_PRIO = 0 → grants alternate P0, P1, P0…; rvalids alternate one cycle later.
- Fixed priority: FIXED_PRIO = 1, both req for 4 cycles → only m0_gnt. Then drop m0_req → m1_gnt the same cycle.
- Lock expiry: port 1 holds req and lock, MAX_LOCK = 4, port 0 requesting → m1_gnt for exactly 4 cycles, then m0_gnt the next cycle, then arbitration resumes.
- Reset mid-read: read granted, then rst asserted before the next edge → no rvalid. After release, the first contention grants port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port block-RAM arbiter.
//   arb_state_e : arbiter FSM state (IDLE, LOCK0, LOCK1)
//   P0 / P1     : port index constants
//   LOCK_CW     : width of the lock-hold cycle counter (MAX_LOCK <= 255)
//   other_port  : returns the opposite port index
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    localparam int unsigned LOCK_CW = 8;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational winner selection between two requesters.
//   req_i         [1:0] request lines, bit i = port i
//   rr_last_i           port granted most recently
//   force_yield_i       a lock just expired; contention goes to the
//                       port other than rr_last_i even in fixed-priority mode
//   valid_o             at least one request is present
//   port_o              winning port index (meaningful when valid_o = 1)
module rr_pick2
    import mem_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    input  logic       force_yield_i,
    output logic       valid_o,
    output logic       port_o
);

    always_comb begin
        valid_o = |req_i;
        port_o  = P0;
        unique case (req_i)
            2'b01: port_o = P0;
            2'b10: port_o = P1;
            2'b11: begin
                if ((FIXED_PRIO != 0) && !force_yield_i) begin
                    port_o = P0;
                end else begin
                    port_o = other_port(rr_last_i);
                end
            end
            default: port_o = P0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Shares one single-port block RAM (1-cycle registered read) between two
// requesters. Port 0 is the CPU path, port 1 a loader/debug/DMA master.
// Grants are round-robin or fixed priority, with a bounded lock that lets a
// port keep ownership for up to MAX_LOCK consecutive cycles.
//   clk, rst                 clock, asynchronous active-low reset
//   mN_req/we/lock/addr/wdata requester N access request
//   mN_gnt                   combinational grant for this cycle
//   mN_rvalid/rdata          read return, one cycle after a granted read
//   ram_we/addr/wdata        RAM command (zero when nothing is granted)
//   ram_rdata                RAM read data, valid the cycle after the address
module mem_arbiter_2p
    import mem_arb_pkg::*;
#(
    parameter int unsigned SIZE       = 14,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic            m0_lock,
    input  logic [SIZE-1:0] m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic            m1_lock,
    input  logic [SIZE-1:0] m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,

    output logic            ram_we,
    output logic [SIZE-1:0] ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);

    localparam logic [LOCK_CW-1:0] MAX_LOCK_C = LOCK_CW'(MAX_LOCK);
    localparam logic [LOCK_CW-1:0] ONE_C      = LOCK_CW'(1);

    arb_state_e          state_q, state_d;
    logic                rr_last_q, rr_last_d;
    logic [LOCK_CW-1:0]  lock_cnt_q, lock_cnt_d;
    logic                force_yield_q, force_yield_d;
    // Per-port: lock input ignored after a forced yield until the next IDLE grant.
    logic [1:0]          lock_blk_q, lock_blk_d;
    // One-hot read tag; doubles as the registered rvalid pair.
    logic [1:0]          rd_tag_q, rd_tag_d;

    logic [1:0]          req_v, lock_v, we_v;
    logic [1:0]          gnt_raw, gnt;
    logic                pick_valid, pick_port;
    logic                own;
    logic [LOCK_CW-1:0]  cnt_inc;

    assign req_v  = {m1_req,  m0_req};
    assign lock_v = {m1_lock, m0_lock};
    assign we_v   = {m1_we,   m0_we};

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req_i         (req_v),
        .rr_last_i     (rr_last_q),
        .force_yield_i (force_yield_q),
        .valid_o       (pick_valid),
        .port_o        (pick_port)
    );

    assign own     = (state_q == ST_LOCK1) ? P1 : P0;
    assign cnt_inc = lock_cnt_q + ONE_C;

    // Grant and next-state decision.
    always_comb begin
        gnt_raw       = '0;
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        lock_cnt_d    = lock_cnt_q;
        force_yield_d = force_yield_q;
        lock_blk_d    = lock_blk_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_raw[pick_port] = 1'b1;
                    rr_last_d          = pick_port;
                    // The yielded-to port has now had its turn.
                    if (pick_port != rr_last_q) begin
                        force_yield_d = 1'b0;
                    end
                    if (lock_blk_q[pick_port]) begin
                        lock_blk_d[pick_port] = 1'b0;
                    end else if (lock_v[pick_port]) begin
                        if (MAX_LOCK_C == ONE_C) begin
                            // A one-cycle lock expires at its own grant.
                            force_yield_d         = 1'b1;
                            lock_blk_d[pick_port] = 1'b1;
                        end else begin
                            state_d    = (pick_port == P1) ? ST_LOCK1 : ST_LOCK0;
                            lock_cnt_d = ONE_C;
                        end
                    end
                end
            end

            ST_LOCK0, ST_LOCK1: begin
                gnt_raw[own] = req_v[own];
                if (req_v[own]) begin
                    rr_last_d = own;
                end
                // lock_cnt counts cycles already held, so cnt_inc is this cycle's ordinal.
                lock_cnt_d = cnt_inc;
                if (!lock_v[own]) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else if (cnt_inc >= MAX_LOCK_C) begin
                    state_d         = ST_IDLE;
                    lock_cnt_d      = '0;
                    rr_last_d       = own;
                    force_yield_d   = 1'b1;
                    lock_blk_d[own] = 1'b1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Grants are forced low while reset is held so the RAM sees no access.
    assign gnt    = rst ? gnt_raw : 2'b00;
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    assign rd_tag_d = gnt & ~we_v;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt[0]) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (gnt[1]) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rr_last_q     <= P1;
            lock_cnt_q    <= '0;
            force_yield_q <= 1'b0;
            lock_blk_q    <= '0;
            rd_tag_q      <= '0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            lock_cnt_q    <= lock_cnt_d;
            force_yield_q <= force_yield_d;
            lock_blk_q    <= lock_blk_d;
            rd_tag_q      <= rd_tag_d;
        end
    end

    assign m0_rvalid = rd_tag_q[0];
    assign m1_rvalid = rd_tag_q[1];
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;

endmodule
